// File: rtl/bidirectional_piso_serializer.sv
// Parallel-in serial-out shifter with per-word direction select.
// Words are sent MSB-first (dir=0) or LSB-first (dir=1); en stalls.
module bidirectional_piso_serializer #(
  parameter int MSB = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_valid,
  input  logic [MSB-1:0] load_data,
  input  logic           dir,
  input  logic           en,
  output logic           load_ready,
  output logic           sout,
  output logic           sout_valid,
  output logic           busy,
  output logic           done
);

  localparam int CW = (MSB > 2) ? $clog2(MSB) : 1;
  localparam logic [CW-1:0] LAST = CW'(MSB - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e         state_q;
  logic [MSB-1:0] shreg_q;
  logic [MSB-1:0] shreg_d;
  logic [CW-1:0]  cnt_q;
  logic           dir_q;
  logic           done_q;

  // Vacated bit is zero-filled so the register drains to 0.
  always_comb begin
    shreg_d = shreg_q;
    if (dir_q) begin
      shreg_d = {1'b0, shreg_q[MSB-1:1]};
    end else begin
      shreg_d = {shreg_q[MSB-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (load_valid) begin
            shreg_q <= load_data;
            dir_q   <= dir;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (en) begin
            shreg_q <= shreg_d;
            if (cnt_q == LAST) begin
              cnt_q   <= '0;
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign load_ready = (state_q == IDLE);
  assign busy       = (state_q == SHIFT);
  assign sout_valid = busy & en;
  assign done       = done_q;

  always_comb begin
    sout = 1'b0;
    if (busy) begin
      sout = dir_q ? shreg_q[0] : shreg_q[MSB-1];
    end
  end

endmodule

// File: tb/tb_bidirectional_piso_serializer.sv
// Scoreboard bench: directed vectors on MSB=4, random loopback
// into a SIPO model on MSB=2 and MSB=8 instances.
module tb_bidirectional_piso_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int fin_cnt = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic       rst, lv, dr, en;
  logic [3:0] ld;
  logic       rdy, so, sv, bsy, dn;
  bit         exp4[$];

  bidirectional_piso_serializer #(.MSB(4)) u4 (
    .clk(clk), .rst(rst), .load_valid(lv), .load_data(ld),
    .dir(dr), .en(en), .load_ready(rdy), .sout(so),
    .sout_valid(sv), .busy(bsy), .done(dn)
  );

  always @(negedge clk) begin
    bit b;
    if (!rst && sv) begin
      if (exp4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL u4_extra_bit got %b want none", so);
      end else begin
        b = exp4.pop_front();
        chk1("u4_sout", so, b);
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_rnd
    localparam int W = (g == 0) ? 2 : 8;
    logic         r_rst, r_lv, r_dr, r_en;
    logic [W-1:0] r_ld;
    logic         r_rdy, r_so, r_sv, r_bsy, r_dn;
    logic [W:0]   expq[$];
    logic [W-1:0] acc;
    int           nb;

    bidirectional_piso_serializer #(.MSB(W)) u_r (
      .clk(clk), .rst(r_rst), .load_valid(r_lv), .load_data(r_ld),
      .dir(r_dr), .en(r_en), .load_ready(r_rdy), .sout(r_so),
      .sout_valid(r_sv), .busy(r_bsy), .done(r_dn)
    );

    initial begin
      r_en = 1'b0;
      forever begin
        @(posedge clk);
        #1 r_en = ($urandom_range(3) != 0);
      end
    end

    initial begin
      int t;
      r_rst = 1'b1;
      r_lv  = 1'b0;
      r_dr  = 1'b0;
      r_ld  = '0;
      acc   = '0;
      nb    = 0;
      repeat (3) @(posedge clk);
      #1 r_rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
        t = 0;
        while (!r_rdy && t < 200) begin
          tick();
          t++;
        end
        if (!r_rdy) begin
          checks++;
          errors++;
          $display("FAIL rnd%0d_ready_timeout got 0 want 1", W);
        end
        r_ld = W'($urandom);
        r_dr = 1'($urandom_range(1));
        r_lv = 1'b1;
        expq.push_back({r_dr, r_ld});
        tick();
        r_lv = 1'b0;
      end
      t = 0;
      while (expq.size() != 0 && t < 1000) begin
        tick();
        t++;
      end
      chkw($sformatf("rnd%0d_drain", W), 32'(expq.size()), 32'd0);
      fin_cnt++;
    end

    // Loopback SIPO: dir 0 enters at the LSB, dir 1 at the MSB.
    always @(negedge clk) begin
      logic [W:0] w;
      if (!r_rst && r_dn) begin
        chkw($sformatf("rnd%0d_done_align", W), 32'(nb), 32'd0);
      end
      if (!r_rst && r_sv) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rnd%0d_extra_bit got %b want none", W, r_so);
        end else begin
          w = expq[0];
          if (w[W]) acc = {r_so, acc[W-1:1]};
          else      acc = {acc[W-2:0], r_so};
          nb++;
          if (nb == W) begin
            w  = expq.pop_front();
            nb = 0;
            chkw($sformatf("rnd%0d_word", W), 32'(acc), 32'(w[W-1:0]));
          end
        end
      end
    end
  end

  initial begin
    int t;
    rst = 1'b1;
    lv  = 1'b0;
    dr  = 1'b0;
    en  = 1'b1;
    ld  = '0;
    #1;
    chk1("rst_ready", rdy, 1'b1);
    chk1("rst_busy", bsy, 1'b0);
    chk1("rst_sout", so, 1'b0);
    chk1("rst_valid", sv, 1'b0);
    chk1("rst_done", dn, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    chk1("idle_en_ignored", bsy, 1'b0);

    ld = 4'b1011; dr = 1'b0; lv = 1'b1;
    exp4.push_back(1); exp4.push_back(0);
    exp4.push_back(1); exp4.push_back(1);
    tick();
    lv = 1'b0;
    chk1("t1_busy", bsy, 1'b1);
    chk1("t1_ready", rdy, 1'b0);
    repeat (3) tick();
    chk1("t1_not_done", dn, 1'b0);
    tick();
    chk1("t1_done", dn, 1'b1);
    chk1("t1_ready_after", rdy, 1'b1);
    tick();
    chk1("t1_done_pulse", dn, 1'b0);

    ld = 4'b1011; dr = 1'b1; lv = 1'b1;
    exp4.push_back(1); exp4.push_back(1);
    exp4.push_back(0); exp4.push_back(1);
    tick();
    lv = 1'b0;
    repeat (4) tick();
    chk1("t2_done", dn, 1'b1);
    tick();
    chk1("t2_done_pulse", dn, 1'b0);

    ld = 4'b0110; dr = 1'b0; lv = 1'b1;
    exp4.push_back(0); exp4.push_back(1);
    exp4.push_back(1); exp4.push_back(0);
    tick();
    lv = 1'b0;
    tick();
    tick();
    en = 1'b0;
    #1;
    chk1("t3_stall_sout", so, 1'b1);
    chk1("t3_stall_valid", sv, 1'b0);
    tick();
    chk1("t3_stall2_sout", so, 1'b1);
    chk1("t3_stall2_busy", bsy, 1'b1);
    tick();
    en = 1'b1;
    tick();
    chk1("t3_not_done", dn, 1'b0);
    tick();
    chk1("t3_done", dn, 1'b1);
    tick();

    ld = 4'b1011; dr = 1'b0; lv = 1'b1;
    exp4.push_back(1); exp4.push_back(0);
    tick();
    lv = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk1("t4_busy", bsy, 1'b0);
    chk1("t4_ready", rdy, 1'b1);
    chk1("t4_sout", so, 1'b0);
    chk1("t4_valid", sv, 1'b0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk1("t4_no_done", dn, 1'b0);
    end

    ld = 4'b1100; dr = 1'b0; lv = 1'b1;
    exp4.push_back(1); exp4.push_back(1);
    exp4.push_back(0); exp4.push_back(0);
    tick();
    chk1("t5_a_busy", bsy, 1'b1);
    ld = 4'b0101; dr = 1'b1;
    repeat (3) tick();
    chk1("t5_a_still_busy", bsy, 1'b1);
    tick();
    chk1("t5_a_done", dn, 1'b1);
    chk1("t5_a_ready", rdy, 1'b1);
    exp4.push_back(1); exp4.push_back(0);
    exp4.push_back(1); exp4.push_back(0);
    tick();
    lv = 1'b0;
    chk1("t5_b_busy", bsy, 1'b1);
    chk1("t5_done_clear", dn, 1'b0);
    repeat (4) tick();
    chk1("t5_b_done", dn, 1'b1);
    tick();
    tick();
    chkw("u4_drain", 32'(exp4.size()), 32'd0);

    t = 0;
    while (fin_cnt < 2 && t < 20000) begin
      tick();
      t++;
    end
    if (fin_cnt < 2) begin
      checks++;
      errors++;
      $display("FAIL rnd_timeout got %0d want 2", fin_cnt);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
